spu_issue_ctrl: RTL and testbench
=================================

// Module: spu_issue_ctrl
// PURPOSE
//  Dual-issue stage feeding the even/odd execution pipes: accepts decoded instruction pairs from decode,
//  checks RAW/WAW hazards against an in-flight scoreboard, routes each instruction to its pipe, splits
//  pairs that cannot co-issue, and drives registered opcode/address/immediate inputs of both pipes.
// PARAMETERS
//  NUM_REGS     128  architectural registers (scoreboard depth)
//  REG_ADDR_WD  7    register address width
//  IMM_WD       18   raw immediate width per instruction
//  LAT_WD       3    latency/scoreboard counter width (latencies 1..7)
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous, active-high reset
//  flush        in   1         drop held pair (branch redirect)
//  dec_valid    in   1         decode presents a pair
//  dec_ready    out  1         issue stage accepts the pair this cycle
//  dec_inst     in   2x dec_inst_t  [0]=older, [1]=younger: vld, opcode, pipe(EVEN/ODD), ra/rb/rc/rt addr,
//                              uses_ra/rb/rc, rt_wr, lat[LAT_WD], imm[0:IMM_WD-1]
//  opcode_ep/op out  Opcodes   opcode to even/odd pipe
//  ra/rb/rc/rt_addr_ep/op out 7  register addresses to each pipe
//  in_I7e..in_I18e, in_I7o..in_I18o out 7/8/10/16/18  immediates, low bits of imm
// BEHAVIOUR
//  - Reset: opcodes = OPC_NOP_E / OPC_NOP_O, all addresses and immediates 0, scoreboard all 0,
//    pair buffer EMPTY, dec_ready=1 in first cycle after reset.
//  - Pair buffer FSM: EMPTY -> FULL on dec_valid&dec_ready. FULL -> EMPTY on dual issue (or single
//    issue when inst1 invalid); FULL -> HALF when only inst0 issues; HALF -> EMPTY when inst1 issues.
//    dec_ready = EMPTY, or buffer fully drains this cycle (back-to-back accept, no bubble).
//  - Latency: pair accepted at edge k issues at edge k+1 earliest; pipe outputs are flops.
//  - Scoreboard: per reg a LAT_WD down-counter; on issue with rt_wr, cnt[rt] <= lat; otherwise
//    decrement each cycle, saturate at 0. A source (uses_rX) is ready when cnt == 0.
//    Issue and decrement to same reg in same cycle: issue wins.
//  - inst0 issues iff all its sources ready and (no rt_wr or cnt[rt] <= lat) (WAW ordering).
//  - inst1 co-issues with inst0 iff inst0 issues, pipes differ, inst1 sources ready, inst1 sources
//    != inst0 rt (when inst0 rt_wr), and inst1 rt != inst0 rt. Else inst1 is held (HALF); inst1
//    never issues before inst0.
//  - Idle pipe in a cycle gets its NOP opcode with rt_wr suppressed; addresses/immediates then 0.
//  - Immediates: I7=imm[IMM_WD-7:], I8, I10, I16 likewise low bits, I18=imm.
//  - flush: buffer -> EMPTY next edge, nothing issues that cycle, pair on dec_* not accepted;
//    scoreboard keeps counting (in-flight ops still retire).
//  - rst mid-operation overrides flush and issue; all state returns to reset values.
// STRUCTURE
//  - defines_pkg: dec_inst_t, pipe_sel_e {PIPE_EVEN, PIPE_ODD}, OPC_NOP_E, OPC_NOP_O, per-opcode latency.
//  - Sub-module spu_scoreboard: counter array, 2x3 source-ready lookups and 2 rt-count lookups,
//    2 set ports, global decrement. Top holds pair FSM, hazard/route logic, output flops.
// TESTING
//  1 Pair {even add r3<-r1,r2 lat2; odd shuffle r4<-r5 lat3}, clean SB -> both issue next edge,
//    dec_ready stays 1.
//  2 Pair both EVEN -> inst0 at k+1, even NOP-free inst1 at k+2, odd pipe NOP both cycles.
//  3 inst0 writes r5 lat 6; next pair reads r5 -> reader issues exactly 6 cycles after writer;
//    dec_ready low meanwhile.
//  4 Intra-pair RAW: inst1 reads inst0 rt, different pipes -> split, inst1 issues after cnt=0.
//  5 flush in HALF -> inst1 never issues, both pipes NOP, SB counts still decrement to 0.
//  6 rst asserted in FULL with SB nonzero -> next cycle all outputs NOP/0, SB 0, dec_ready 1.

Source files
------------

// File: rtl/spu_issue_ctrl_pkg.sv
// Shared types for the SPU dual-issue stage: decoded instruction, pipe select,
// opcodes with their nominal latencies, and the per-pipe output bundle.
package spu_issue_ctrl_pkg;

  localparam int unsigned NUM_REGS    = 128;
  localparam int unsigned REG_ADDR_WD = 7;
  localparam int unsigned IMM_WD      = 18;
  localparam int unsigned LAT_WD      = 3;

  typedef logic [REG_ADDR_WD-1:0] reg_addr_t;
  typedef logic [LAT_WD-1:0]      lat_t;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_sel_e;

  typedef enum logic [7:0] {
    OPC_NOP_E = 8'h00,
    OPC_NOP_O = 8'h01,
    OPC_ADD   = 8'h10,
    OPC_AND   = 8'h11,
    OPC_FMA   = 8'h12,
    OPC_DIV   = 8'h13,
    OPC_SHUF  = 8'h20,
    OPC_LQD   = 8'h21,
    OPC_BR    = 8'h22,
    OPC_ROT   = 8'h23
  } opcode_e;

  typedef struct packed {
    logic              vld;
    opcode_e           opcode;
    pipe_sel_e         pipe;
    reg_addr_t         ra;
    reg_addr_t         rb;
    reg_addr_t         rc;
    reg_addr_t         rt;
    logic              uses_ra;
    logic              uses_rb;
    logic              uses_rc;
    logic              rt_wr;
    lat_t              lat;
    logic [IMM_WD-1:0] imm;
  } dec_inst_t;

  typedef struct packed {
    opcode_e           opcode;
    reg_addr_t         ra;
    reg_addr_t         rb;
    reg_addr_t         rc;
    reg_addr_t         rt;
    logic [IMM_WD-1:0] imm;
  } pipe_out_t;

  function automatic lat_t opc_latency(input opcode_e op);
    case (op)
      OPC_AND, OPC_BR: return lat_t'(1);
      OPC_ADD:         return lat_t'(2);
      OPC_SHUF:        return lat_t'(3);
      OPC_ROT:         return lat_t'(4);
      OPC_FMA, OPC_LQD: return lat_t'(6);
      OPC_DIV:         return lat_t'(7);
      default:         return lat_t'(1);
    endcase
  endfunction

  function automatic pipe_out_t nop_out(input opcode_e nop);
    pipe_out_t o;
    o = '0;
    o.opcode = nop;
    return o;
  endfunction

  function automatic pipe_out_t to_out(input dec_inst_t i);
    pipe_out_t o;
    o.opcode = i.opcode;
    o.ra     = i.ra;
    o.rb     = i.rb;
    o.rc     = i.rc;
    o.rt     = i.rt;
    o.imm    = i.imm;
    return o;
  endfunction

endpackage

// File: rtl/spu_issue_ctrl_scoreboard.sv
// In-flight scoreboard: one saturating down-counter per register, loaded with
// the producer latency on issue; a register is readable once its count is 0.
module spu_issue_ctrl_scoreboard
  import spu_issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  reg_addr_t [1:0][2:0] src_addr_i,
  output logic      [1:0][2:0] src_rdy_o,
  input  reg_addr_t [1:0]      rt_addr_i,
  output lat_t      [1:0]      rt_cnt_o,
  input  logic      [1:0]      set_en_i,
  input  lat_t      [1:0]      set_lat_i
);

  lat_t cnt_q [NUM_REGS];

  // A set on the same edge as the decrement wins; the two set ports never collide.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (set_en_i[0] && rt_addr_i[0] == reg_addr_t'(i)) begin
        cnt_q[i] <= set_lat_i[0];
      end else if (set_en_i[1] && rt_addr_i[1] == reg_addr_t'(i)) begin
        cnt_q[i] <= set_lat_i[1];
      end else if (cnt_q[i] != '0) begin
        cnt_q[i] <= cnt_q[i] - lat_t'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rt_cnt_o[p] = cnt_q[rt_addr_i[p]];
      for (int unsigned s = 0; s < 3; s++) begin
        src_rdy_o[p][s] = (cnt_q[src_addr_i[p][s]] == '0);
      end
    end
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// Dual-issue stage: holds one decoded pair, checks hazards against the
// scoreboard, routes to even/odd pipes and splits pairs that cannot co-issue.
module spu_issue_ctrl
  import spu_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  dec_inst_t [1:0] dec_inst,
  output opcode_e         opcode_ep,
  output opcode_e         opcode_op,
  output reg_addr_t       ra_addr_ep,
  output reg_addr_t       rb_addr_ep,
  output reg_addr_t       rc_addr_ep,
  output reg_addr_t       rt_addr_ep,
  output reg_addr_t       ra_addr_op,
  output reg_addr_t       rb_addr_op,
  output reg_addr_t       rc_addr_op,
  output reg_addr_t       rt_addr_op,
  output logic [6:0]      in_I7e,
  output logic [7:0]      in_I8e,
  output logic [9:0]      in_I10e,
  output logic [15:0]     in_I16e,
  output logic [17:0]     in_I18e,
  output logic [6:0]      in_I7o,
  output logic [7:0]      in_I8o,
  output logic [9:0]      in_I10o,
  output logic [15:0]     in_I16o,
  output logic [17:0]     in_I18o
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FULL  = 2'd1,
    BUF_HALF  = 2'd2
  } buf_state_e;

  buf_state_e      state_q, state_d;
  dec_inst_t [1:0] inst_q;
  pipe_out_t       pe_q, pe_d, po_q, po_d;

  dec_inst_t head, tail;
  logic head_go, tail_go, intra_raw, drain, accept;

  reg_addr_t [1:0][2:0] sb_src;
  logic      [1:0][2:0] sb_rdy;
  reg_addr_t [1:0]      sb_rt;
  lat_t      [1:0]      sb_cnt;
  logic      [1:0]      sb_set;
  lat_t      [1:0]      sb_lat;

  function automatic logic src_ok(input dec_inst_t i, input logic [2:0] rdy);
    return (!i.uses_ra || rdy[0]) && (!i.uses_rb || rdy[1]) && (!i.uses_rc || rdy[2]);
  endfunction

  spu_issue_ctrl_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .src_addr_i (sb_src),
    .src_rdy_o  (sb_rdy),
    .rt_addr_i  (sb_rt),
    .rt_cnt_o   (sb_cnt),
    .set_en_i   (sb_set),
    .set_lat_i  (sb_lat)
  );

  // In HALF the held younger instruction becomes the head and obeys the oldest-instruction rules.
  always_comb begin
    head      = (state_q == BUF_HALF) ? inst_q[1] : inst_q[0];
    tail      = inst_q[1];
    sb_src[0] = {head.rc, head.rb, head.ra};
    sb_src[1] = {tail.rc, tail.rb, tail.ra};
    sb_rt[0]  = head.rt;
    sb_rt[1]  = tail.rt;

    head_go = (state_q != BUF_EMPTY) && !flush && src_ok(head, sb_rdy[0]) &&
              (!head.rt_wr || (sb_cnt[0] <= head.lat));
    intra_raw = head.rt_wr && ((tail.uses_ra && tail.ra == head.rt) ||
                               (tail.uses_rb && tail.rb == head.rt) ||
                               (tail.uses_rc && tail.rc == head.rt));
    tail_go = (state_q == BUF_FULL) && head_go && tail.vld && (tail.pipe != head.pipe) &&
              src_ok(tail, sb_rdy[1]) && !intra_raw &&
              !(head.rt_wr && tail.rt_wr && tail.rt == head.rt);
    drain     = head_go && ((state_q == BUF_HALF) || !tail.vld || tail_go);
    dec_ready = !flush && ((state_q == BUF_EMPTY) || drain);
    accept    = dec_valid && dec_ready;

    pe_d = nop_out(OPC_NOP_E);
    po_d = nop_out(OPC_NOP_O);
    if (head_go && head.vld) begin
      if (head.pipe == PIPE_EVEN) pe_d = to_out(head);
      else                        po_d = to_out(head);
    end
    if (tail_go) begin
      if (tail.pipe == PIPE_EVEN) pe_d = to_out(tail);
      else                        po_d = to_out(tail);
    end

    sb_set[0] = head_go && head.vld && head.rt_wr;
    sb_set[1] = tail_go && tail.rt_wr;
    sb_lat    = {tail.lat, head.lat};

    state_d = state_q;
    if (flush)        state_d = BUF_EMPTY;
    else if (accept)  state_d = BUF_FULL;
    else if (drain)   state_d = BUF_EMPTY;
    else if (head_go) state_d = BUF_HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      inst_q  <= '0;
      pe_q    <= nop_out(OPC_NOP_E);
      po_q    <= nop_out(OPC_NOP_O);
    end else begin
      state_q <= state_d;
      if (accept) inst_q <= dec_inst;
      pe_q <= pe_d;
      po_q <= po_d;
    end
  end

  assign opcode_ep  = pe_q.opcode;
  assign ra_addr_ep = pe_q.ra;
  assign rb_addr_ep = pe_q.rb;
  assign rc_addr_ep = pe_q.rc;
  assign rt_addr_ep = pe_q.rt;
  assign in_I7e     = pe_q.imm[6:0];
  assign in_I8e     = pe_q.imm[7:0];
  assign in_I10e    = pe_q.imm[9:0];
  assign in_I16e    = pe_q.imm[15:0];
  assign in_I18e    = pe_q.imm;

  assign opcode_op  = po_q.opcode;
  assign ra_addr_op = po_q.ra;
  assign rb_addr_op = po_q.rb;
  assign rc_addr_op = po_q.rc;
  assign rt_addr_op = po_q.rt;
  assign in_I7o     = po_q.imm[6:0];
  assign in_I8o     = po_q.imm[7:0];
  assign in_I10o    = po_q.imm[9:0];
  assign in_I16o    = po_q.imm[15:0];
  assign in_I18o    = po_q.imm;

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Bench for spu_issue_ctrl: directed scenarios plus random traffic, all checked
// against a timestamp-based scoreboard model and a queue of held instructions.
module tb_spu_issue_ctrl;
  import spu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, dec_valid, dec_ready;
  dec_inst_t [1:0] dec_inst;
  opcode_e   opcode_ep, opcode_op;
  reg_addr_t ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  reg_addr_t ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [6:0]  in_I7e, in_I7o;
  logic [7:0]  in_I8e, in_I8o;
  logic [9:0]  in_I10e, in_I10o;
  logic [15:0] in_I16e, in_I16o;
  logic [17:0] in_I18e, in_I18o;

  always #5 clk = ~clk;

  spu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst),
    .opcode_ep(opcode_ep), .opcode_op(opcode_op),
    .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
    .in_I7e(in_I7e), .in_I8e(in_I8e), .in_I10e(in_I10e), .in_I16e(in_I16e), .in_I18e(in_I18e),
    .in_I7o(in_I7o), .in_I8o(in_I8o), .in_I10o(in_I10o), .in_I16o(in_I16o), .in_I18o(in_I18o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model: ready_at[r] is the cycle from which register r may be read.
  int        ready_at [NUM_REGS];
  int        cyc = 0;
  dec_inst_t held [$];
  bit        exp_busy [2];
  dec_inst_t exp_pipe [2];
  bit        m_accept;

  opcode_e ops [8] = '{OPC_ADD, OPC_AND, OPC_FMA, OPC_DIV, OPC_SHUF, OPC_LQD, OPC_BR, OPC_ROT};
  dec_inst_t NOI = '0;

  function automatic bit srcs_ready(input dec_inst_t i);
    return (!i.uses_ra || ready_at[i.ra] <= cyc) && (!i.uses_rb || ready_at[i.rb] <= cyc) &&
           (!i.uses_rc || ready_at[i.rc] <= cyc);
  endfunction

  function automatic bit reads(input dec_inst_t i, input reg_addr_t r);
    return (i.uses_ra && i.ra == r) || (i.uses_rb && i.rb == r) || (i.uses_rc && i.rc == r);
  endfunction

  task automatic model_reset();
    held.delete();
    for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    exp_busy[0] = 0;
    exp_busy[1] = 0;
    m_accept = 0;
  endtask

  task automatic issue(input dec_inst_t i);
    int p;
    p = (i.pipe == PIPE_EVEN) ? 0 : 1;
    exp_busy[p] = 1;
    exp_pipe[p] = i;
  endtask

  task automatic model_step(output bit exp_ready);
    bit go0, go1;
    int n_go;
    dec_inst_t h, t;
    go0 = 0;
    go1 = 0;
    exp_busy[0] = 0;
    exp_busy[1] = 0;
    if (!flush && held.size() > 0) begin
      h = held[0];
      go0 = srcs_ready(h) && (!h.rt_wr || (ready_at[h.rt] - cyc <= int'(h.lat)));
      if (go0 && held.size() == 2) begin
        t = held[1];
        go1 = (t.pipe != h.pipe) && srcs_ready(t) && !(h.rt_wr && reads(t, h.rt)) &&
              !(h.rt_wr && t.rt_wr && h.rt == t.rt);
      end
    end
    n_go = int'(go0) + int'(go1);
    exp_ready = !flush && (held.size() == 0 || n_go == held.size());
    if (go0) begin
      issue(h);
      if (h.rt_wr) ready_at[h.rt] = cyc + 1 + int'(h.lat);
    end
    if (go1) begin
      issue(t);
      if (t.rt_wr) ready_at[t.rt] = cyc + 1 + int'(t.lat);
    end
    if (flush) held.delete();
    else repeat (n_go) void'(held.pop_front());
    m_accept = dec_valid && exp_ready;
    if (m_accept) begin
      held.push_back(dec_inst[0]);
      if (dec_inst[1].vld) held.push_back(dec_inst[1]);
    end
  endtask

  task automatic check_outputs();
    dec_inst_t e, o;
    e = exp_busy[0] ? exp_pipe[0] : '0;
    o = exp_busy[1] ? exp_pipe[1] : '0;
    check("opc_e", 32'(opcode_ep), exp_busy[0] ? 32'(e.opcode) : 32'(OPC_NOP_E));
    check("ra_e", 32'(ra_addr_ep), 32'(e.ra));
    check("rb_e", 32'(rb_addr_ep), 32'(e.rb));
    check("rc_e", 32'(rc_addr_ep), 32'(e.rc));
    check("rt_e", 32'(rt_addr_ep), 32'(e.rt));
    check("I7e", 32'(in_I7e), 32'(e.imm[6:0]));
    check("I8e", 32'(in_I8e), 32'(e.imm[7:0]));
    check("I10e", 32'(in_I10e), 32'(e.imm[9:0]));
    check("I16e", 32'(in_I16e), 32'(e.imm[15:0]));
    check("I18e", 32'(in_I18e), 32'(e.imm));
    check("opc_o", 32'(opcode_op), exp_busy[1] ? 32'(o.opcode) : 32'(OPC_NOP_O));
    check("ra_o", 32'(ra_addr_op), 32'(o.ra));
    check("rb_o", 32'(rb_addr_op), 32'(o.rb));
    check("rc_o", 32'(rc_addr_op), 32'(o.rc));
    check("rt_o", 32'(rt_addr_op), 32'(o.rt));
    check("I7o", 32'(in_I7o), 32'(o.imm[6:0]));
    check("I8o", 32'(in_I8o), 32'(o.imm[7:0]));
    check("I10o", 32'(in_I10o), 32'(o.imm[9:0]));
    check("I16o", 32'(in_I16o), 32'(o.imm[15:0]));
    check("I18o", 32'(in_I18o), 32'(o.imm));
  endtask

  // One clock: drive just after a negedge, predict, then check registered outputs at the next negedge.
  task automatic step(input bit r, input bit f, input bit v, input dec_inst_t i0, input dec_inst_t i1);
    bit er;
    rst = r;
    flush = f;
    dec_valid = v;
    dec_inst[0] = i0;
    dec_inst[1] = i1;
    #1;
    if (r) model_reset();
    else begin
      model_step(er);
      check("dec_ready", 32'(dec_ready), 32'(er));
    end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, NOI, NOI);
  endtask

  function automatic dec_inst_t mk(input opcode_e op, input pipe_sel_e p, input int rt, input bit wr,
                                   input int ra, input bit ua, input int rb, input bit ub, input int lat);
    dec_inst_t d;
    d = '0;
    d.vld = 1'b1;
    d.opcode = op;
    d.pipe = p;
    d.rt = reg_addr_t'(rt);
    d.rt_wr = wr;
    d.ra = reg_addr_t'(ra);
    d.uses_ra = ua;
    d.rb = reg_addr_t'(rb);
    d.uses_rb = ub;
    d.lat = lat_t'(lat);
    d.imm = IMM_WD'($urandom);
    return d;
  endfunction

  function automatic dec_inst_t rnd_inst(input bit v);
    dec_inst_t d;
    d.vld = v;
    d.opcode = ops[$urandom_range(0, 7)];
    d.pipe = ($urandom_range(0, 1) == 0) ? PIPE_EVEN : PIPE_ODD;
    d.ra = reg_addr_t'($urandom_range(0, 7));
    d.rb = reg_addr_t'($urandom_range(0, 7));
    d.rc = reg_addr_t'($urandom_range(0, 7));
    d.rt = reg_addr_t'($urandom_range(0, 7));
    d.uses_ra = ($urandom_range(0, 1) == 1);
    d.uses_rb = ($urandom_range(0, 1) == 1);
    d.uses_rc = ($urandom_range(0, 3) == 0);
    d.rt_wr = ($urandom_range(0, 3) != 0);
    d.lat = ($urandom_range(0, 1) == 1) ? opc_latency(d.opcode) : lat_t'($urandom_range(1, 7));
    d.imm = IMM_WD'($urandom);
    return d;
  endfunction

  initial begin
    dec_inst_t w, rd;
    int gap, hits, pend;
    bit seen_w, got, r, f, v, v1;

    rst = 1'b1;
    flush = 1'b0;
    dec_valid = 1'b0;
    dec_inst = '0;
    model_reset();
    @(negedge clk);
    step(1, 0, 0, NOI, NOI);

    // 1: clean dual issue
    step(0, 0, 1, mk(OPC_ADD, PIPE_EVEN, 3, 1, 1, 1, 2, 1, 2), mk(OPC_SHUF, PIPE_ODD, 4, 1, 5, 1, 0, 0, 3));
    step(0, 0, 0, NOI, NOI);
    check("t1_even", 32'(opcode_ep), 32'(OPC_ADD));
    check("t1_odd", 32'(opcode_op), 32'(OPC_SHUF));
    idle(8);

    // 2: both even -> split over two cycles
    step(0, 0, 1, mk(OPC_ADD, PIPE_EVEN, 6, 1, 1, 1, 0, 0, 2), mk(OPC_AND, PIPE_EVEN, 7, 1, 2, 1, 0, 0, 1));
    idle(10);

    // 3: RAW across pairs, lat 6 -> six stall cycles on the even pipe
    w  = mk(OPC_FMA, PIPE_EVEN, 5, 1, 0, 0, 0, 0, 6);
    rd = mk(OPC_ADD, PIPE_EVEN, 12, 1, 5, 1, 0, 0, 2);
    step(0, 0, 1, w, NOI);
    pend = 1; seen_w = 0; got = 0; gap = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, pend[0], rd, NOI);
      if (pend == 1 && m_accept) pend = 0;
      if (seen_w && opcode_ep == OPC_ADD) got = 1;
      else if (seen_w) gap++;
      if (opcode_ep == OPC_FMA) seen_w = 1;
    end
    check("t3_reached", 32'(got), 32'd1);
    check("t3_gap", gap, 32'd6);
    idle(10);

    // 4: intra-pair RAW, different pipes
    step(0, 0, 1, mk(OPC_ADD, PIPE_EVEN, 8, 1, 1, 1, 0, 0, 3), mk(OPC_SHUF, PIPE_ODD, 9, 1, 8, 1, 0, 0, 3));
    idle(10);

    // 5: flush while HALF drops the younger instruction
    step(0, 0, 1, mk(OPC_FMA, PIPE_EVEN, 10, 1, 0, 0, 0, 0, 6), mk(OPC_LQD, PIPE_ODD, 13, 1, 10, 1, 0, 0, 6));
    step(0, 0, 0, NOI, NOI);
    step(0, 1, 0, NOI, NOI);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, NOI, NOI);
      if (opcode_op == OPC_LQD) hits++;
    end
    check("t5_flushed", hits, 32'd0);
    step(0, 0, 1, mk(OPC_AND, PIPE_EVEN, 1, 0, 10, 1, 0, 0, 1), NOI);
    idle(3);

    // 6: reset while FULL with a pending count
    step(0, 0, 1, mk(OPC_DIV, PIPE_EVEN, 11, 1, 0, 0, 0, 0, 7), NOI);
    step(0, 0, 1, mk(OPC_ADD, PIPE_EVEN, 14, 1, 11, 1, 0, 0, 2), NOI);
    step(0, 0, 0, NOI, NOI);
    step(1, 0, 0, NOI, NOI);
    step(0, 0, 1, mk(OPC_AND, PIPE_EVEN, 15, 1, 11, 1, 0, 0, 1), NOI);
    step(0, 0, 0, NOI, NOI);
    check("t6_sb_clear", 32'(opcode_ep), 32'(OPC_AND));
    idle(3);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      step(r, f, v, rnd_inst(1'b1), rnd_inst(v1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
